// File: rtl/seq_sched.sv
// Sequence scheduler: visits masked sources in ascending order and captures their terms into an output FIFO.
// Optional abort input is enabled by defining SEQ_SCHED_ABORT_EN.
module seq_sched #(
  parameter int NSRC       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NSRC-1:0]   req_mask,
  input  logic [3:0]        term_count,
  input  logic [8*NSRC-1:0] src_data,
  output logic [NSRC-1:0]   src_step,
  output logic [NSRC-1:0]   src_restart,
  output logic [7:0]        out_data,
  output logic [2:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SEQ_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done
);

  localparam int SW = $clog2(NSRC);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = SW + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RESTART, S_CAPTURE, S_STEP, S_NEXT, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [NSRC-1:0]   mask_lat, mask_next;
  logic [3:0]        tc_lat, tc_next;
  logic [SW-1:0]     sel, sel_next;
  logic [4:0]        term_cnt, term_next;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, push, pop, abort_hit;
  logic [SW-1:0]     lowest, above;
  logic              found_above;
  logic [4:0]        term_limit;
  logic              last_term;
  logic [EW-1:0]     head;

`ifdef SEQ_SCHED_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready && !abort_hit;
  assign busy       = (state != S_IDLE);
  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head[7:0] : 8'd0;
  assign out_src    = out_valid ? 3'(head[EW-1:8]) : 3'd0;
  assign term_limit = (tc_lat == 4'd0) ? 5'd16 : {1'b0, tc_lat};
  assign last_term  = ((term_cnt + 5'd1) == term_limit);

  // Lowest requested source at start, and next latched source strictly above sel.
  always_comb begin
    lowest      = '0;
    above       = '0;
    found_above = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_mask[i]) lowest = SW'(i);
    end
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (mask_lat[i] && (i > int'(sel))) begin
        above       = SW'(i);
        found_above = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    mask_next   = mask_lat;
    tc_next     = tc_lat;
    sel_next    = sel;
    term_next   = term_cnt;
    push        = 1'b0;
    src_step    = '0;
    src_restart = '0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (req_mask != '0) begin
            mask_next  = req_mask;
            tc_next    = term_count;
            sel_next   = lowest;
            state_next = S_RESTART;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_RESTART: begin
        src_restart[sel] = 1'b1;
        term_next        = '0;
        state_next       = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!full) begin
          push       = 1'b1;
          term_next  = term_cnt + 5'd1;
          state_next = last_term ? S_NEXT : S_STEP;
        end
      end
      S_STEP: begin
        src_step[sel] = 1'b1;
        state_next    = S_CAPTURE;
      end
      S_NEXT: begin
        if (found_above) begin
          sel_next   = above;
          state_next = S_RESTART;
        end else begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_hit) begin
      state_next  = S_IDLE;
      push        = 1'b0;
      src_step    = '0;
      src_restart = '0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mask_lat <= '0;
      tc_lat   <= '0;
      sel      <= '0;
      term_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      mask_lat <= mask_next;
      tc_lat   <= tc_next;
      sel      <= sel_next;
      term_cnt <= term_next;
      if (abort_hit) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is left unreset; out_data/out_src are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel, src_data[{sel, 3'b000} +: 8]};
  end

endmodule

// File: tb/tb_seq_sched.sv
// Directed testbench for seq_sched with behavioural counter / Fibonacci / Sylvester sources.
module tb_seq_sched;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [7:0]  req_mask;
  logic [3:0]  term_count;
  logic [63:0] src_data;
  logic [7:0]  src_step, src_restart, out_data;
  logic [2:0]  out_src;
  logic        out_valid, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_sched #(.NSRC(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .req_mask    (req_mask),
    .term_count  (term_count),
    .src_data    (src_data),
    .src_step    (src_step),
    .src_restart (src_restart),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef SEQ_SCHED_ABORT_EN
    .abort       (1'b0),
`endif
    .busy        (busy),
    .done        (done)
  );

  // Source 3 = Fibonacci (1,1), source 7 = Sylvester (2), all others = counter (1).
  logic [7:0] sa [8];
  logic [7:0] sb [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset) begin
        sa[i] <= 8'd0;
        sb[i] <= 8'd0;
      end else if (src_restart[i]) begin
        sa[i] <= (i == 7) ? 8'd2 : 8'd1;
        sb[i] <= 8'd1;
      end else if (src_step[i]) begin
        if (i == 3) begin
          sa[i] <= sb[i];
          sb[i] <= sa[i] + sb[i];
        end else if (i == 7) begin
          sa[i] <= sa[i] * sa[i] - sa[i] + 8'd1;
        end else begin
          sa[i] <= sa[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    src_data = '0;
    for (int i = 0; i < 8; i++) src_data[8*i +: 8] = sa[i];
  end

  logic [10:0] got [$];
  int step_cnt = 0, rs_cnt = 0, done_cnt = 0, onehot_err = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back({out_src, out_data});
    step_cnt <= step_cnt + $countones(src_step);
    rs_cnt   <= rs_cnt + $countones(src_restart);
    if (done) done_cnt <= done_cnt + 1;
    if ($countones(src_step | src_restart) > 1) onehot_err <= onehot_err + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 300 && done_cnt == base; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; req_mask = 8'h00; term_count = 4'd0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {busy, done, out_valid});
    end
    checks++;
    if ({src_step, src_restart} !== 16'h0000) begin
      failures++; $display("FAIL reset_pulses got=%h want=0000", {src_step, src_restart});
    end
    checks++;
    if ({out_src, out_data} !== 11'h000) begin
      failures++; $display("FAIL reset_data got=%h want=000", {out_src, out_data});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fib();
    logic [10:0] exp [5] = '{{3'd3, 8'd1}, {3'd3, 8'd1}, {3'd3, 8'd2}, {3'd3, 8'd3}, {3'd3, 8'd5}};
    int b_got = got.size();
    int b_done = done_cnt;
    logic [10:0] v;
    out_ready = 1'b1; req_mask = 8'h08; term_count = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || src_restart !== 8'h08) begin
      failures++; $display("FAIL fib_restart got busy=%b restart=%h want busy=1 restart=08", busy, src_restart);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL fib_latency_capture got valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd3, 8'd1}) begin
      failures++; $display("FAIL fib_first_out got v=%b src=%0d data=%0d want v=1 src=3 data=1", out_valid, out_src, out_data);
    end
    wait_done(b_done);
    tick();
    checks++;
    if (done_cnt - b_done != 1 || got.size() - b_got != 5) begin
      failures++; $display("FAIL fib_counts got done=%0d terms=%0d want done=1 terms=5", done_cnt - b_done, got.size() - b_got);
    end
    for (int k = 0; k < 5; k++) begin
      v = (b_got + k < got.size()) ? got[b_got + k] : 11'h7ff;
      checks++;
      if (v !== exp[k]) begin
        failures++; $display("FAIL fib_term%0d got=%h want=%h", k, v, exp[k]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL fib_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_two_src();
    logic [10:0] exp [4] = '{{3'd0, 8'd1}, {3'd0, 8'd2}, {3'd7, 8'd2}, {3'd7, 8'd3}};
    int b_got = got.size();
    int b_done = done_cnt;
    int b_rs = rs_cnt;
    int b_st = step_cnt;
    logic [10:0] v;
    out_ready = 1'b1; req_mask = 8'h81; term_count = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(b_done);
    tick();
    checks++;
    if (got.size() - b_got != 4 || rs_cnt - b_rs != 2 || step_cnt - b_st != 2) begin
      failures++; $display("FAIL two_counts got terms=%0d restarts=%0d steps=%0d want 4 2 2",
                           got.size() - b_got, rs_cnt - b_rs, step_cnt - b_st);
    end
    for (int k = 0; k < 4; k++) begin
      v = (b_got + k < got.size()) ? got[b_got + k] : 11'h7ff;
      checks++;
      if (v !== exp[k]) begin
        failures++; $display("FAIL two_term%0d got=%h want=%h", k, v, exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int b_got = got.size();
    int b_done = done_cnt;
    int b_st = step_cnt;
    int b_rs = rs_cnt;
    int mid_st;
    logic [10:0] v;
    out_ready = 1'b0; req_mask = 8'h01; term_count = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if (step_cnt - b_st != 4 || rs_cnt - b_rs != 1) begin
      failures++; $display("FAIL bp_stall_pulses got steps=%0d restarts=%0d want 4 1", step_cnt - b_st, rs_cnt - b_rs);
    end
    checks++;
    if ({busy, out_valid, out_src, out_data} !== {1'b1, 1'b1, 3'd0, 8'd1}) begin
      failures++; $display("FAIL bp_head got busy=%b v=%b src=%0d data=%0d want 1 1 0 1", busy, out_valid, out_src, out_data);
    end
    mid_st = step_cnt;
    repeat (5) tick();
    checks++;
    if (step_cnt != mid_st || {out_src, out_data} !== {3'd0, 8'd1}) begin
      failures++; $display("FAIL bp_stuck got extra_steps=%0d head=%h want 0 001", step_cnt - mid_st, {out_src, out_data});
    end
    out_ready = 1'b1;
    wait_done(b_done);
    tick();
    checks++;
    if (got.size() - b_got != 6 || step_cnt - b_st != 5 || done_cnt - b_done != 1) begin
      failures++; $display("FAIL bp_counts got terms=%0d steps=%0d done=%0d want 6 5 1",
                           got.size() - b_got, step_cnt - b_st, done_cnt - b_done);
    end
    for (int k = 0; k < 6; k++) begin
      v = (b_got + k < got.size()) ? got[b_got + k] : 11'h7ff;
      checks++;
      if (v !== {3'd0, 8'(k + 1)}) begin
        failures++; $display("FAIL bp_term%0d got=%h want=%h", k, v, {3'd0, 8'(k + 1)});
      end
    end
  endtask

  task automatic test_sixteen();
    int b_got = got.size();
    int b_done = done_cnt;
    int b_st = step_cnt;
    int b_rs = rs_cnt;
    int bad = 0;
    logic [10:0] v;
    out_ready = 1'b1; req_mask = 8'h02; term_count = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(b_done);
    tick();
    checks++;
    if (got.size() - b_got != 16 || step_cnt - b_st != 15 || rs_cnt - b_rs != 1) begin
      failures++; $display("FAIL sixteen_counts got terms=%0d steps=%0d restarts=%0d want 16 15 1",
                           got.size() - b_got, step_cnt - b_st, rs_cnt - b_rs);
    end
    for (int k = 0; k < 16; k++) begin
      v = (b_got + k < got.size()) ? got[b_got + k] : 11'h7ff;
      if (v !== {3'd1, 8'(k + 1)}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL sixteen_values got bad_terms=%0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int b_got = got.size();
    int b_done = done_cnt;
    out_ready = 1'b0; req_mask = 8'h08; term_count = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (out_valid !== 1'b1 || src_step !== 8'h08) begin
      failures++; $display("FAIL mid_pre got v=%b step=%h want 1 08", out_valid, src_step);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, out_valid, src_step, src_restart, out_src, out_data} !== 30'd0) begin
      failures++; $display("FAIL mid_reset_outputs got busy=%b done=%b v=%b step=%h rs=%h src=%0d data=%0d want all 0",
                           busy, done, out_valid, src_step, src_restart, out_src, out_data);
    end
    tick();
    reset = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cnt != b_done || got.size() != b_got || out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_no_done got done=%0d terms=%0d v=%b want 0 0 0",
                           done_cnt - b_done, got.size() - b_got, out_valid);
    end
    req_mask = 8'h00; term_count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b11) begin
      failures++; $display("FAIL empty_done got done=%b busy=%b want 1 1", done, busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00 || got.size() != b_got || done_cnt - b_done != 1) begin
      failures++; $display("FAIL empty_after got done=%b busy=%b terms=%0d dones=%0d want 0 0 0 1",
                           done, busy, got.size() - b_got, done_cnt - b_done);
    end
  endtask

  task automatic test_onehot();
    checks++;
    if (onehot_err != 0) begin
      failures++; $display("FAIL onehot got violations=%0d want 0", onehot_err);
    end
  endtask

  initial begin
    test_reset();
    test_fib();
    test_two_src();
    test_backpressure();
    test_sixteen();
    test_reset_mid();
    test_onehot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
